// File: rtl/sram_access_sequencer.sv
// Sequences cache single-word accesses and fixed-length bursts onto the SRAM offset path.
// Optional burst preemption by cache accesses: define SRAM_CACHE_PREEMPT_EN.
module sram_access_sequencer #(
    parameter int unsigned OFFSET_W  = 7,
    parameter int unsigned BURST_LEN = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cache_req,
    input  logic [OFFSET_W-1:0] cache_offset,
    input  logic                cache_we,
    output logic                cache_grant,
    input  logic                burst_start,
    input  logic                burst_we,
    output logic                burst_busy,
    output logic                burst_done,
    input  logic                sram_ready,
    output logic                sram_req,
    output logic                sram_we,
    output logic                offset_select,
    output logic [OFFSET_W-1:0] sram_offset,
    output logic [OFFSET_W-1:0] count_out
);

    typedef enum logic [1:0] {IDLE, CACHE, BURST, DONE} state_t;

    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(BURST_LEN - 1);

    state_t              state_q, state_d;
    logic [OFFSET_W-1:0] count_q, count_d;
    logic                burst_pend_q, burst_pend_d;
    logic [OFFSET_W-1:0] cache_offset_q, cache_offset_d;
    logic                cache_we_q, cache_we_d;
    logic                burst_we_q, burst_we_d;
    logic                cache_grant_q, cache_grant_d;
    logic                burst_done_q, burst_done_d;
    logic                burst_busy_q, burst_busy_d;
    logic                sram_req_q, sram_req_d;
    logic                sram_we_q, sram_we_d;
    logic                offset_select_q, offset_select_d;
    logic [OFFSET_W-1:0] sram_offset_q, sram_offset_d;

    logic accept, cache_go, start_ok;

`ifdef SRAM_CACHE_PREEMPT_EN
    logic resume_q, resume_d;
`else
    logic resume_d;
    assign resume_d = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        burst_pend_d   = burst_pend_q;
        cache_offset_d = cache_offset_q;
        cache_we_d     = cache_we_q;
        burst_we_d     = burst_we_q;
        cache_grant_d  = 1'b0;
        burst_done_d   = 1'b0;
`ifdef SRAM_CACHE_PREEMPT_EN
        resume_d       = resume_q;
`endif

        accept   = sram_req_q & sram_ready;
        cache_go = cache_req & ~cache_grant_q;
        start_ok = burst_start & ~burst_busy_q;

        // A start accepted while a cache access owns the path is parked in burst_pend.
        if (start_ok) begin
            burst_pend_d = 1'b1;
            burst_we_d   = burst_we;
        end

        unique case (state_q)
            IDLE: begin
                if (cache_go) begin
                    state_d        = CACHE;
                    cache_offset_d = cache_offset;
                    cache_we_d     = cache_we;
                end else if (burst_pend_d) begin
                    state_d      = BURST;
                    count_d      = '0;
                    burst_pend_d = 1'b0;
                end
            end
            CACHE: begin
                if (accept) begin
                    cache_grant_d = 1'b1;
                    state_d       = IDLE;
`ifdef SRAM_CACHE_PREEMPT_EN
                    if (resume_q) begin
                        state_d  = BURST;
                        resume_d = 1'b0;
                    end
`endif
                end
            end
            BURST: begin
                if (accept) begin
                    if (count_q == LAST_BEAT) begin
                        state_d      = DONE;
                        burst_done_d = 1'b1;
                    end else begin
                        count_d = count_q + OFFSET_W'(1);
`ifdef SRAM_CACHE_PREEMPT_EN
                        if (cache_go) begin
                            state_d        = CACHE;
                            resume_d       = 1'b1;
                            cache_offset_d = cache_offset;
                            cache_we_d     = cache_we;
                        end
`endif
                    end
                end
            end
            DONE: begin
                count_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next-state values.
        sram_req_d      = (state_d == CACHE) || (state_d == BURST);
        offset_select_d = (state_d == CACHE);
        sram_offset_d   = '0;
        sram_we_d       = 1'b0;
        if (state_d == CACHE) begin
            sram_offset_d = cache_offset_d;
            sram_we_d     = cache_we_d;
        end else if (state_d == BURST) begin
            sram_offset_d = count_d;
            sram_we_d     = burst_we_d;
        end
        burst_busy_d = burst_pend_d || (state_d == BURST) || (state_d == DONE) || resume_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            count_q         <= '0;
            burst_pend_q    <= 1'b0;
            cache_offset_q  <= '0;
            cache_we_q      <= 1'b0;
            burst_we_q      <= 1'b0;
            cache_grant_q   <= 1'b0;
            burst_done_q    <= 1'b0;
            burst_busy_q    <= 1'b0;
            sram_req_q      <= 1'b0;
            sram_we_q       <= 1'b0;
            offset_select_q <= 1'b0;
            sram_offset_q   <= '0;
`ifdef SRAM_CACHE_PREEMPT_EN
            resume_q        <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            burst_pend_q    <= burst_pend_d;
            cache_offset_q  <= cache_offset_d;
            cache_we_q      <= cache_we_d;
            burst_we_q      <= burst_we_d;
            cache_grant_q   <= cache_grant_d;
            burst_done_q    <= burst_done_d;
            burst_busy_q    <= burst_busy_d;
            sram_req_q      <= sram_req_d;
            sram_we_q       <= sram_we_d;
            offset_select_q <= offset_select_d;
            sram_offset_q   <= sram_offset_d;
`ifdef SRAM_CACHE_PREEMPT_EN
            resume_q        <= resume_d;
`endif
        end
    end

    assign cache_grant   = cache_grant_q;
    assign burst_done    = burst_done_q;
    assign burst_busy    = burst_busy_q;
    assign sram_req      = sram_req_q;
    assign sram_we       = sram_we_q;
    assign offset_select = offset_select_q;
    assign sram_offset   = sram_offset_q;
    assign count_out     = count_q;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Scoreboard bench for sram_access_sequencer: expected accesses/grants/dones are queued by
// the stimulus and popped by an independent monitor.
module tb_sram_access_sequencer;

    localparam int unsigned OW = 7;
    localparam int unsigned BL = 128;
    localparam int K_ACC = 0, K_GRANT = 1, K_DONE = 2;

    typedef struct {
        int         kind;
        logic [8:0] acc;   // {we, offset_select, offset}
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cache_req, cache_we, burst_start, burst_we, sram_ready;
    logic [OW-1:0] cache_offset;
    logic          cache_grant, burst_busy, burst_done, sram_req, sram_we, offset_select;
    logic [OW-1:0] sram_offset, count_out;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic ready_en = 1'b0;
    logic stall_en = 1'b0;
    int   cyc = 0;

    sram_access_sequencer #(.OFFSET_W(OW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .cache_req(cache_req), .cache_offset(cache_offset), .cache_we(cache_we),
        .cache_grant(cache_grant),
        .burst_start(burst_start), .burst_we(burst_we), .burst_busy(burst_busy),
        .burst_done(burst_done),
        .sram_ready(sram_ready), .sram_req(sram_req), .sram_we(sram_we),
        .offset_select(offset_select), .sram_offset(sram_offset), .count_out(count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [8:0] acc);
        exp_t e;
        e.kind = kind;
        e.acc  = acc;
        sb.push_back(e);
    endtask

    task automatic push_beats(input logic we, input int first, input int last);
        for (int k = first; k <= last; k++) push(K_ACC, {we, 1'b0, OW'(k)});
    endtask

    task automatic sb_pop(input int kind, input logic [8:0] acc);
        exp_t e;
        if (sb.size() == 0) begin
            check($sformatf("unexpected_event_kind%0d", kind), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("event_kind_exp%0d", e.kind), kind, e.kind);
            if (kind == K_ACC && e.kind == K_ACC)
                check($sformatf("access_exp_%0h", e.acc), acc, e.acc);
        end
    endtask

    function automatic logic [19:0] all_outs();
        return {cache_grant, burst_busy, burst_done, sram_req, sram_we, offset_select,
                sram_offset, count_out};
    endfunction

    // SRAM ready model: optionally withholds ready every third cycle
    initial begin
        sram_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            sram_ready = ready_en && !(stall_en && (cyc % 3 == 0));
        end
    end

    // Monitor: a grant and a beat acceptance can share a cycle; the grant is queued first
    initial begin
        forever begin
            @(negedge clk);
            if (cache_grant) sb_pop(K_GRANT, '0);
            if (burst_done) sb_pop(K_DONE, '0);
            if (sram_req && sram_ready) sb_pop(K_ACC, {sram_we, offset_select, sram_offset});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cache_access(input logic [OW-1:0] off, input logic we);
        logic got;
        push(K_ACC, {we, 1'b1, off});
        push(K_GRANT, '0);
        @(posedge clk); #1;
        cache_req = 1'b1; cache_offset = off; cache_we = we;
        @(negedge clk);
        @(negedge clk);
        check("cache_sram_req_t1", sram_req, 1);
        check("cache_select_t1", offset_select, 1);
        check("cache_offset_t1", sram_offset, off);
        check("cache_we_t1", sram_we, we);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cache_grant) begin got = 1'b1; break; end
        end
        check("cache_grant_seen", got, 1);
        @(posedge clk); #1;
        cache_req = 1'b0;
        @(negedge clk);
        check("cache_grant_one_cycle", cache_grant, 0);
    endtask

    task automatic run_burst(input logic we, input logic poke);
        logic done, poked;
        push_beats(we, 0, BL - 1);
        push(K_DONE, '0);
        @(posedge clk); #1;
        burst_start = 1'b1; burst_we = we;
        @(posedge clk); #1;
        burst_start = 1'b0;
        done = 1'b0; poked = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (burst_done) begin done = 1'b1; break; end
            if (poke && !poked && count_out == OW'(64)) begin
                poked = 1'b1;
                @(posedge clk); #1;
                burst_start = 1'b1; burst_we = ~we;
                @(posedge clk); #1;
                burst_start = 1'b0;
            end
        end
        check("burst_done_seen", done, 1);
        if (poke) check("burst_poke_issued", poked, 1);
        @(negedge clk);
        check("burst_busy_after_done", burst_busy, 0);
        check("burst_done_one_cycle", burst_done, 0);
        check("burst_req_after_done", sram_req, 0);
        if (poke) begin
            repeat (3) @(negedge clk);
            check("burst_no_restart", {burst_busy, sram_req}, 2'b00);
        end
    endtask

    initial begin
        logic ok, busy_ok, done_seen, grant_seen, req_set;
        rst = 1'b1; cache_req = 1'b0; cache_offset = '0; cache_we = 1'b0;
        burst_start = 1'b0; burst_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_values", all_outs(), '0);
        @(posedge clk); #1;
        rst = 1'b0; ready_en = 1'b1;

        cache_access(7'h2A, 1'b1);
        stall_en = 1'b1;
        cache_access(7'h55, 1'b0);
        stall_en = 1'b0;

        // Reset while the burst presents offset 40: beats 0..39 only
        push_beats(1'b1, 0, 39);
        @(posedge clk); #1;
        burst_start = 1'b1; burst_we = 1'b1;
        @(posedge clk); #1;
        burst_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (count_out == OW'(39)) begin ok = 1'b1; break; end
        end
        check("reset_burst_reached_39", ok, 1);
        @(posedge clk); #1;
        rst = 1'b1; ready_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_burst", all_outs(), '0);
        @(posedge clk); #1;
        rst = 1'b0; ready_en = 1'b1;
        @(negedge clk);
        check("after_reset_idle", all_outs(), '0);

        stall_en = 1'b1;
        run_burst(1'b0, 1'b0);
        stall_en = 1'b0;
        run_burst(1'b1, 1'b1);

        // Cache and burst requested together: cache first, burst follows from burst_pend
        push(K_ACC, {1'b0, 1'b1, 7'h11});
        push(K_GRANT, '0);
        push_beats(1'b1, 0, BL - 1);
        push(K_DONE, '0);
        @(posedge clk); #1;
        cache_req = 1'b1; cache_offset = 7'h11; cache_we = 1'b0;
        burst_start = 1'b1; burst_we = 1'b1;
        @(posedge clk); #1;
        burst_start = 1'b0;
        busy_ok = 1'b1; done_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!burst_busy) busy_ok = 1'b0;
            if (burst_done) begin done_seen = 1'b1; break; end
            if (cache_grant) begin
                @(posedge clk); #1;
                cache_req = 1'b0;
            end
        end
        check("combo_done_seen", done_seen, 1);
        check("combo_busy_held", busy_ok, 1);
        cache_req = 1'b0;
        @(negedge clk);
        check("combo_busy_cleared", burst_busy, 0);

        // Cache request arriving during beat 10
`ifdef SRAM_CACHE_PREEMPT_EN
        push_beats(1'b1, 0, 10);
        push(K_ACC, {1'b0, 1'b1, 7'h05});
        push(K_GRANT, '0);
        push_beats(1'b1, 11, BL - 1);
        push(K_DONE, '0);
`else
        push_beats(1'b1, 0, BL - 1);
        push(K_DONE, '0);
        push(K_ACC, {1'b0, 1'b1, 7'h05});
        push(K_GRANT, '0);
`endif
        @(posedge clk); #1;
        burst_start = 1'b1; burst_we = 1'b1;
        @(posedge clk); #1;
        burst_start = 1'b0;
        done_seen = 1'b0; grant_seen = 1'b0; req_set = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (burst_done) done_seen = 1'b1;
            if (cache_grant) grant_seen = 1'b1;
            if (done_seen && grant_seen) break;
            if (cache_grant) begin
                @(posedge clk); #1;
                cache_req = 1'b0;
            end else if (!req_set && sram_req && count_out == OW'(9)) begin
                req_set = 1'b1;
                @(posedge clk); #1;
                cache_req = 1'b1; cache_offset = 7'h05; cache_we = 1'b0;
            end
        end
        @(posedge clk); #1;
        cache_req = 1'b0;
        check("preempt_done_seen", done_seen, 1);
        check("preempt_grant_seen", grant_seen, 1);

        repeat (4) @(negedge clk);
        check("final_idle", all_outs(), '0);
        check("scoreboard_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_access_sequencer.md
# sram_access_sequencer

Sequences all accesses to the stripe SRAM offset path. It arbitrates between single-word cache accesses and 128-word burst transfers, and it owns the burst offset counter. It drives the cache-versus-counter select and the resulting offset into the SRAM controller. It sits between the cache/parity logic and the SRAM controller, wrapping the offset mux.

## Interface
Parameters:
- OFFSET_W, 7, width of the SRAM word offset
- BURST_LEN, 128, beats per burst; must be in the range 2..2^OFFSET_W

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cache_req  in  1  cache access request; held until cache_grant
- cache_offset  in  OFFSET_W  offset for the cache access; stable while cache_req is high
- cache_we  in  1  write (1) or read (0) for the cache access
- cache_grant  out  1  one-cycle pulse; the cache access was accepted
- burst_start  in  1  one-cycle pulse that starts a burst
- burst_we  in  1  direction of the burst; sampled with burst_start
- burst_busy  out  1  burst pending or in progress
- burst_done  out  1  one-cycle pulse after the last beat is accepted
- sram_ready  in  1  SRAM controller accepts the current access
- sram_req  out  1  access valid
- sram_we  out  1  access direction
- offset_select  out  1  1 selects the cache offset, 0 selects the burst counter
- sram_offset  out  OFFSET_W  offset presented to the SRAM controller
- count_out  out  OFFSET_W  burst counter value

## Operation
- States: IDLE, CACHE, BURST, DONE. All outputs are registered.
- Acceptance: an access is accepted in any cycle where sram_req and sram_ready are both 1.
- IDLE:
  - If cache_req is 1 and cache_grant is 0, go to CACHE. Latch cache_offset and cache_we; set offset_select to 1.
  - Otherwise, if burst_start is 1 or burst_pend is 1, go to BURST. Set count to 0, offset_select to 0, latch the direction, and clear burst_pend.
- Simultaneous cache_req and burst_start in IDLE: cache wins. burst_start sets burst_pend, so the burst is not lost.
- CACHE: hold sram_req at 1. On acceptance, pulse cache_grant in the next cycle, then go to IDLE. IDLE ignores cache_req while cache_grant is 1.
- BURST:
  - sram_req is 1, sram_offset equals count, sram_we equals the latched burst_we.
  - On acceptance, if count equals BURST_LEN-1, go to DONE. Otherwise increment count.
  - Without acceptance, count holds.
- DONE: pulse burst_done, reset count to 0, deassert sram_req, go to IDLE.
- burst_start while burst_busy is 1 is ignored; it is neither queued nor restarting the burst.
- burst_busy = burst_pend OR state in {BURST, DONE} OR resume (see Configuration).
- count never exceeds BURST_LEN-1. There is no wrap past the terminal value.
- rst mid-operation:
  - Aborts any access within one cycle.
  - Clears burst_pend and resume.
  - No grant or done pulse is issued for the aborted operation.

## Timing
- Reset values: every output is 0, state is IDLE, count is 0.
- Cache latency: cache_req rises in cycle t (IDLE), so sram_req=1 at t+1. With sram_ready=1 at t+1, cache_grant=1 at t+2.
- Burst latency: burst_start at t. With sram_ready held at 1, beats occupy t+1 .. t+BURST_LEN, and burst_done=1 at t+BURST_LEN+1.
- sram_req, sram_offset, offset_select and sram_we change only on clk edges. They are stable while sram_req=1 and sram_ready=0.
- Back-to-back: a new cache access can start at the earliest 2 cycles after its predecessor's acceptance.

## Configuration
- SRAM_CACHE_PREEMPT_EN defined:
  - In BURST, on acceptance of a non-final beat with cache_req=1, increment count, set resume, and go to CACHE.
  - After the cache access is accepted, go to BURST, not IDLE, with count preserved and offset_select=0. Clear resume.
- SRAM_CACHE_PREEMPT_EN undefined:
  - cache_req waits until the burst finishes (through DONE then IDLE).
  - The resume logic is absent; resume is constant 0.

## Test plan
- Reset: assert rst for 2 cycles mid-burst at count=40. All outputs are 0 and count_out=0; the following burst restarts at offset 0.
- Single cache write: cache_offset=7'h2A, cache_we=1, sram_ready=1.
  - sram_offset=0x2A with offset_select=1 one cycle after cache_req.
  - cache_grant pulses one cycle later.
- Full burst with sram_ready stalled low every 3rd cycle:
  - Offsets 0..127 are each accepted exactly once, in order.
  - burst_done pulses once; burst_busy falls with it.
- cache_req and burst_start in the same cycle:
  - The cache access is served first, with grant.
  - The burst then starts at offset 0 without a second burst_start.
  - burst_busy stays 1 throughout.
- Preempt (SRAM_CACHE_PREEMPT_EN): cache_req=1 arrives during beat 10.
  - The cache access to 0x05 follows beat 10.
  - The next burst beat is offset 11. Without the macro, the cache access happens after burst_done.
- burst_start pulsed at count=64: ignored. Exactly 128 beats, then one burst_done.
